// File: rtl/rf_pkg.sv
`default_nettype none
// ============================================================================
// Module      : rf_pkg
// Description : Shared defaults and forwarding-source encoding for the
//               forwarding register file.
// Revision    : 1.0 - initial release
// ============================================================================
package rf_pkg;

    localparam int c_DEF_DATA_W = 16;
    localparam int c_DEF_ADDR_W = 5;

    typedef enum logic [1:0] {
        FWD_BANK = 2'd0,
        FWD_EX   = 2'd1,
        FWD_DM   = 2'd2,
        FWD_WB   = 2'd3
    } fwd_sel_e;

endpackage
`default_nettype wire

// File: rtl/rf_fwd_sel.sv
`default_nettype none
// ============================================================================
// Module      : rf_fwd_sel
// Description : Forwarding source select for one source register address.
//               Youngest matching valid tag wins: EX > DM > WB > BANK.
// Revision    : 1.0 - initial release
// ============================================================================
module rf_fwd_sel
    import rf_pkg::*;
#(
    parameter int ADDR_W = c_DEF_ADDR_W
) (
    input  logic [ADDR_W-1:0] i_src,
    input  logic              i_ex_v,
    input  logic [ADDR_W-1:0] i_ex_a,
    input  logic              i_dm_v,
    input  logic [ADDR_W-1:0] i_dm_a,
    input  logic              i_wb_v,
    input  logic [ADDR_W-1:0] i_wb_a,
    output fwd_sel_e          o_sel
);

    always_comb begin
        o_sel = FWD_BANK;
        if (i_ex_v && (i_ex_a == i_src)) begin
            o_sel = FWD_EX;
        end else if (i_dm_v && (i_dm_a == i_src)) begin
            o_sel = FWD_DM;
        end else if (i_wb_v && (i_wb_a == i_src)) begin
            o_sel = FWD_WB;
        end
    end

endmodule
`default_nettype wire

// File: rtl/register_file_fwd.sv
`default_nettype none
// ============================================================================
// Module      : register_file_fwd
// Description : Register bank with EX/DM/WB destination-tag pipeline and
//               forwarding into registered EX operands. Optional macro
//               ZERO_REG_EN makes r0 a hardwired zero.
// Revision    : 1.0 - initial release
// ============================================================================
module register_file_fwd
    import rf_pkg::*;
#(
    parameter int DATA_W = c_DEF_DATA_W,
    parameter int ADDR_W = c_DEF_ADDR_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              id_valid,
    input  logic              stall,
    input  logic [ADDR_W-1:0] ra,
    input  logic [ADDR_W-1:0] rb,
    input  logic [ADDR_W-1:0] rw,
    input  logic              rw_en,
    input  logic [DATA_W-1:0] imm,
    input  logic              imm_sel,
    input  logic [DATA_W-1:0] ans_ex,
    input  logic [DATA_W-1:0] ans_dm,
    input  logic [DATA_W-1:0] ans_wb,
    output logic [DATA_W-1:0] op_a,
    output logic [DATA_W-1:0] op_b,
    output logic              op_valid,
    output logic [1:0]        fwd_a,
    output logic [1:0]        fwd_b
);

    localparam int c_DEPTH = 2 ** ADDR_W;

    logic              r_ex_v, r_dm_v, r_wb_v;
    logic [ADDR_W-1:0] r_ex_a, r_dm_a, r_wb_a;
    logic [DATA_W-1:0] r_bank [c_DEPTH];

    logic [DATA_W-1:0] r_op_a, r_op_b;
    logic              r_op_valid;
    fwd_sel_e          r_fwd_a, r_fwd_b;

    logic              w_issue;
    logic              w_ex_tag_v;
    logic [DATA_W-1:0] w_bank_a, w_bank_b;
    logic [DATA_W-1:0] w_val_a, w_val_b;
    fwd_sel_e          w_sel_a, w_sel_b;

    assign w_issue = id_valid & ~stall;

`ifdef ZERO_REG_EN
    // r0 tags never become valid, so r0 is neither written nor forwarded
    assign w_ex_tag_v = w_issue & rw_en & (rw != '0);
    assign w_bank_a   = (ra == '0) ? '0 : r_bank[ra];
    assign w_bank_b   = (rb == '0) ? '0 : r_bank[rb];
`else
    assign w_ex_tag_v = w_issue & rw_en;
    assign w_bank_a   = r_bank[ra];
    assign w_bank_b   = r_bank[rb];
`endif

    rf_fwd_sel #(.ADDR_W(ADDR_W)) u_fwd_sel_a (
        .i_src  (ra),
        .i_ex_v (r_ex_v),
        .i_ex_a (r_ex_a),
        .i_dm_v (r_dm_v),
        .i_dm_a (r_dm_a),
        .i_wb_v (r_wb_v),
        .i_wb_a (r_wb_a),
        .o_sel  (w_sel_a)
    );

    rf_fwd_sel #(.ADDR_W(ADDR_W)) u_fwd_sel_b (
        .i_src  (rb),
        .i_ex_v (r_ex_v),
        .i_ex_a (r_ex_a),
        .i_dm_v (r_dm_v),
        .i_dm_a (r_dm_a),
        .i_wb_v (r_wb_v),
        .i_wb_a (r_wb_a),
        .o_sel  (w_sel_b)
    );

    always_comb begin
        w_val_a = w_bank_a;
        case (w_sel_a)
            FWD_EX:  w_val_a = ans_ex;
            FWD_DM:  w_val_a = ans_dm;
            FWD_WB:  w_val_a = ans_wb;
            default: w_val_a = w_bank_a;
        endcase
    end

    always_comb begin
        w_val_b = w_bank_b;
        case (w_sel_b)
            FWD_EX:  w_val_b = ans_ex;
            FWD_DM:  w_val_b = ans_dm;
            FWD_WB:  w_val_b = ans_wb;
            default: w_val_b = w_bank_b;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ex_v <= 1'b0;
            r_dm_v <= 1'b0;
            r_wb_v <= 1'b0;
            r_ex_a <= '0;
            r_dm_a <= '0;
            r_wb_a <= '0;
        end else begin
            r_ex_v <= w_ex_tag_v;
            r_ex_a <= rw;
            r_dm_v <= r_ex_v;
            r_dm_a <= r_ex_a;
            r_wb_v <= r_dm_v;
            r_wb_a <= r_dm_a;
        end
    end

    // Bank reads above see pre-write contents; a same-edge WB write is
    // covered by the WB forwarding path.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < c_DEPTH; i++) begin
                r_bank[i] <= '0;
            end
        end else if (r_wb_v) begin
            r_bank[r_wb_a] <= ans_wb;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_op_a     <= '0;
            r_op_b     <= '0;
            r_fwd_a    <= FWD_BANK;
            r_fwd_b    <= FWD_BANK;
            r_op_valid <= 1'b0;
        end else begin
            r_op_valid <= w_issue;
            if (w_issue) begin
                r_op_a  <= w_val_a;
                r_op_b  <= imm_sel ? imm : w_val_b;
                r_fwd_a <= w_sel_a;
                r_fwd_b <= w_sel_b;
            end
        end
    end

    assign op_a     = r_op_a;
    assign op_b     = r_op_b;
    assign op_valid = r_op_valid;
    assign fwd_a    = r_fwd_a;
    assign fwd_b    = r_fwd_b;

endmodule
`default_nettype wire

// File: tb/tb_register_file_fwd.sv
`default_nettype none
// ============================================================================
// Module      : tb_register_file_fwd
// Description : Self-checking bench for register_file_fwd with a per-cycle
//               reference model and directed literal expectations.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_register_file_fwd;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        id_valid, stall, rw_en, imm_sel;
    logic [4:0]  ra, rb, rw;
    logic [15:0] imm, ans_ex, ans_dm, ans_wb;
    logic [15:0] op_a, op_b;
    logic        op_valid;
    logic [1:0]  fwd_a, fwd_b;

    int n_pass  = 0;
    int n_total = 0;

    register_file_fwd #(.DATA_W(16), .ADDR_W(5)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .id_valid (id_valid),
        .stall    (stall),
        .ra       (ra),
        .rb       (rb),
        .rw       (rw),
        .rw_en    (rw_en),
        .imm      (imm),
        .imm_sel  (imm_sel),
        .ans_ex   (ans_ex),
        .ans_dm   (ans_dm),
        .ans_wb   (ans_wb),
        .op_a     (op_a),
        .op_b     (op_b),
        .op_valid (op_valid),
        .fwd_a    (fwd_a),
        .fwd_b    (fwd_b)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act !== exp) $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        else n_pass++;
    endtask

    // Reference model: architectural register array plus a list of
    // in-flight destinations, index 0 = youngest (EX).
    logic [15:0] m_bank [32];
    bit          m_tv [3];
    logic [4:0]  m_ta [3];
    logic [15:0] m_a, m_b;
    logic [1:0]  m_fa, m_fb;
    bit          m_ov;

    function automatic void model_reset();
        for (int i = 0; i < 32; i++) m_bank[i] = '0;
        for (int s = 0; s < 3; s++) begin m_tv[s] = 0; m_ta[s] = '0; end
        m_a = '0; m_b = '0; m_fa = '0; m_fb = '0; m_ov = 0;
    endfunction

    function automatic void lookup(input logic [4:0] addr, output logic [15:0] val,
                                   output logic [1:0] sel);
        logic [15:0] ans [3];
        ans[0] = ans_ex; ans[1] = ans_dm; ans[2] = ans_wb;
        sel = 2'd0;
        val = m_bank[addr];
`ifdef ZERO_REG_EN
        if (addr == 5'd0) val = 16'h0;
`endif
        for (int s = 0; s < 3; s++) begin
            if (m_tv[s] && m_ta[s] == addr) begin
                val = ans[s];
                sel = 2'(s + 1);
                break;
            end
        end
    endfunction

    function automatic void model_step();
        logic [15:0] va, vb;
        logic [1:0]  sa, sb;
        bit          issue, newv;
        issue = id_valid && !stall;
        if (issue) begin
            lookup(ra, va, sa);
            lookup(rb, vb, sb);
            m_a = va; m_b = imm_sel ? imm : vb; m_fa = sa; m_fb = sb;
        end
        m_ov = issue;
        if (m_tv[2]) m_bank[m_ta[2]] = ans_wb;
        newv = issue && rw_en;
`ifdef ZERO_REG_EN
        if (rw == 5'd0) newv = 0;
`endif
        for (int s = 2; s > 0; s--) begin m_tv[s] = m_tv[s-1]; m_ta[s] = m_ta[s-1]; end
        m_tv[0] = newv; m_ta[0] = rw;
    endfunction

    initial begin
        model_reset();
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) model_reset();
            else model_step();
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            chk("cyc_op_valid", {31'd0, op_valid}, {31'd0, m_ov});
            chk("cyc_op_a", {16'd0, op_a}, {16'd0, m_a});
            chk("cyc_op_b", {16'd0, op_b}, {16'd0, m_b});
            chk("cyc_fwd_a", {30'd0, fwd_a}, {30'd0, m_fa});
            chk("cyc_fwd_b", {30'd0, fwd_b}, {30'd0, m_fb});
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        id_valid = 0; stall = 0; rw_en = 0; imm_sel = 0;
    endtask

    task automatic issue(input logic [4:0] a, input logic [4:0] b,
                         input logic [4:0] w, input logic we);
        id_valid = 1; stall = 0; imm_sel = 0;
        ra = a; rb = b; rw = w; rw_en = we;
    endtask

    initial begin
        rst_n = 0;
        idle();
        ra = 0; rb = 0; rw = 0; imm = 0;
        ans_ex = 16'h0E0E; ans_dm = 16'h0D0D; ans_wb = 16'h1234;
        repeat (2) tick();
        chk("rst_op_valid", {31'd0, op_valid}, 32'd0);
        chk("rst_op_a", {16'd0, op_a}, 32'd0);
        chk("rst_fwd_a", {30'd0, fwd_a}, 32'd0);
        #2 rst_n = 1;

        // r3 written through the WB tag, then read from the bank
        issue(5'd0, 5'd0, 5'd3, 1'b1); tick();
        idle(); repeat (3) tick();
        issue(5'd3, 5'd0, 5'd0, 1'b0); tick();
        chk("bank_r3_op_a", {16'd0, op_a}, 32'h1234);
        chk("bank_r3_fwd_a", {30'd0, fwd_a}, 32'd0);
        chk("bank_r3_valid", {31'd0, op_valid}, 32'd1);

        // back-to-back dependency from EX
        issue(5'd0, 5'd0, 5'd5, 1'b1); tick();
        issue(5'd5, 5'd0, 5'd0, 1'b0); ans_ex = 16'hAAAA; tick();
        chk("b2b_op_a", {16'd0, op_a}, 32'hAAAA);
        chk("b2b_fwd_a", {30'd0, fwd_a}, 32'd1);

        // r5 in flight in all three stages, then only DM and WB
        issue(5'd0, 5'd0, 5'd5, 1'b1); repeat (3) tick();
        ans_ex = 16'h1111; ans_dm = 16'h2222; ans_wb = 16'h3333;
        issue(5'd5, 5'd0, 5'd0, 1'b0); tick();
        chk("prio_ex_op_a", {16'd0, op_a}, 32'h1111);
        chk("prio_ex_fwd_a", {30'd0, fwd_a}, 32'd1);
        tick();
        chk("prio_dm_op_a", {16'd0, op_a}, 32'h2222);
        chk("prio_dm_fwd_a", {30'd0, fwd_a}, 32'd2);
        idle(); repeat (3) tick();

        // stall bubble while older writes keep draining
        ans_wb = 16'hA10A; ans_ex = 16'h0E0E; ans_dm = 16'h0D0D;
        issue(5'd3, 5'd0, 5'd10, 1'b1); tick();
        chk("pre_stall_op_a", {16'd0, op_a}, 32'h1234);
        idle(); tick();
        issue(5'd5, 5'd0, 5'd7, 1'b1); stall = 1; tick();
        chk("stall_op_valid", {31'd0, op_valid}, 32'd0);
        chk("stall_op_a_held", {16'd0, op_a}, 32'h1234);
        issue(5'd7, 5'd10, 5'd0, 1'b0); ans_ex = 16'h7777; tick();
        chk("bubble_op_a", {16'd0, op_a}, 32'h0);
        chk("bubble_fwd_a", {30'd0, fwd_a}, 32'd0);
        chk("wb_fwd_b", {30'd0, fwd_b}, 32'd3);
        chk("wb_op_b", {16'd0, op_b}, 32'hA10A);
        ans_wb = 16'h5A5A;
        issue(5'd0, 5'd10, 5'd0, 1'b0); tick();
        chk("wb_landed_op_b", {16'd0, op_b}, 32'hA10A);
        chk("wb_landed_fwd_b", {30'd0, fwd_b}, 32'd0);

        // immediate overrides B while fwd_b still reports DM
        issue(5'd0, 5'd0, 5'd9, 1'b1); tick();
        idle(); tick();
        chk("idle_op_valid", {31'd0, op_valid}, 32'd0);
        issue(5'd0, 5'd9, 5'd0, 1'b0); imm_sel = 1; imm = 16'h00FF; ans_dm = 16'h9999; tick();
        chk("imm_op_b", {16'd0, op_b}, 32'h00FF);
        chk("imm_fwd_b", {30'd0, fwd_b}, 32'd2);

        // register 0 behaviour
        issue(5'd0, 5'd0, 5'd0, 1'b1); tick();
        idle(); ans_wb = 16'hBEEF; repeat (3) tick();
        issue(5'd0, 5'd0, 5'd0, 1'b0); tick();
`ifdef ZERO_REG_EN
        chk("r0_op_a", {16'd0, op_a}, 32'h0);
`else
        chk("r0_op_a", {16'd0, op_a}, 32'hBEEF);
`endif
        chk("r0_fwd_a", {30'd0, fwd_a}, 32'd0);

        // asynchronous reset with r12 writes in flight
        ans_wb = 16'hC0DE;
        issue(5'd0, 5'd0, 5'd12, 1'b1); tick(); tick();
        #2 rst_n = 0;
        #1;
        chk("midrst_op_valid", {31'd0, op_valid}, 32'd0);
        chk("midrst_op_a", {16'd0, op_a}, 32'd0);
        chk("midrst_fwd_a", {30'd0, fwd_a}, 32'd0);
        #2 rst_n = 1;
        idle(); repeat (3) tick();
        issue(5'd12, 5'd3, 5'd0, 1'b0); tick();
        chk("post_rst_r12", {16'd0, op_a}, 32'h0);
        chk("post_rst_r3", {16'd0, op_b}, 32'h0);
        chk("post_rst_fwd_a", {30'd0, fwd_a}, 32'd0);
        idle(); repeat (2) tick();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/register_file_fwd.md
REGISTER_FILE_FWD -- requirements
Module: register_file_fwd

Interface
REQ-001 SHALL have parameter DATA_W, default 16, operand/result width in bits.
REQ-002 SHALL have parameter ADDR_W, default 5, register address width; depth = 2**ADDR_W.
REQ-003 clk  in  1  sole clock; all state updates on rising edge.
REQ-004 rst_n  in  1  reset, asynchronous, active-low.
REQ-005 id_valid  in  1  decode stage holds a valid instruction.
REQ-006 stall  in  1  hold decode, insert bubble into EX.
REQ-007 ra, rb  in  ADDR_W each  source register addresses.
REQ-008 rw, rw_en  in  ADDR_W, 1  destination address and write intent of the decode instruction.
REQ-009 imm, imm_sel  in  DATA_W, 1  immediate and B-operand immediate select.
REQ-010 ans_ex, ans_dm, ans_wb  in  DATA_W each  results currently in EX, DM, WB stages.
REQ-011 op_a, op_b  out  DATA_W each  registered operands to EX.
REQ-012 op_valid  out  1  op_a/op_b hold a valid issued instruction.
REQ-013 fwd_a, fwd_b  out  2 each  registered forwarding source used (BANK=0, EX=1, DM=2, WB=3).

Function
REQ-014 Destination tag pipeline SHALL hold {valid, addr} for EX, DM, WB stages.
REQ-015 On each edge, DM<=EX and WB<=DM always; EX<={id_valid & rw_en & !stall, rw}.
REQ-016 Bank write SHALL occur at the edge when WB tag is valid: bank[WB.addr] <= ans_wb.
REQ-017 Forward select per source SHALL be combinational with priority EX > DM > WB > BANK, matching only valid tags with equal address.
REQ-018 BANK path SHALL read the bank contents before the same-edge WB write; WB forwarding covers the bypass.
REQ-019 op_b source SHALL be imm when imm_sel=1, else the forwarded B value; fwd_b still reports the B-path selection.
REQ-020 When id_valid & !stall, op_a/op_b/fwd_a/fwd_b SHALL load and op_valid SHALL be 1 next cycle.
REQ-021 When stall=1 or id_valid=0, op_valid SHALL be 0 next cycle and op_a/op_b/fwd_* SHALL hold.
REQ-022 Issue latency SHALL be exactly one cycle from decode sample to op_* valid.
REQ-023 Simultaneous matches in several stages SHALL select the youngest (EX).
REQ-024 Address arithmetic SHALL be unsigned ADDR_W bits; no wrap beyond depth exists.

Reset
REQ-025 While rst_n=0, all bank entries, op_a, op_b, fwd_a, fwd_b SHALL be 0, op_valid 0, all tags invalid.
REQ-026 Reset asserted mid-operation SHALL discard in-flight tags; the pending WB write SHALL not occur.
REQ-027 First edge after rst_n rises SHALL behave as a normal cycle.

Configuration
REQ-028 Macro ZERO_REG_EN SHALL, when defined, make register 0 read as 0, never written, never forwarded (tags with addr 0 treated invalid).
REQ-029 Without ZERO_REG_EN, register 0 SHALL be an ordinary register.

Structure
REQ-030 Package rf_pkg SHALL hold default DATA_W/ADDR_W constants and the forward-select enumeration.
REQ-031 One sub-module rf_fwd_sel SHALL compute the select for one source address; instantiated twice.

Verification
REQ-032 Reset then write r3 via WB tag with ans_wb=0x1234, later read ra=3 -> op_a=0x1234, fwd_a=BANK.
REQ-033 Back-to-back: instr writes r5, next reads ra=5, ans_ex=0xAAAA -> op_a=0xAAAA, fwd_a=EX.
REQ-034 r5 valid in EX (0x1111), DM (0x2222) and WB (0x3333); read r5 -> op_a=0x1111, fwd_a=EX; with only DM and WB -> 0x2222, DM.
REQ-035 stall=1 one cycle -> op_valid=0, op_a held, EX tag bubble; DM/WB still advance and WB write lands.
REQ-036 imm_sel=1, imm=0x00FF, rb forwarding from DM -> op_b=0x00FF, fwd_b=DM.
REQ-037 With ZERO_REG_EN, write r0=0xBEEF then read ra=0 -> op_a=0, fwd_a=BANK; without it -> 0xBEEF.
